// File: rtl/binop_alu.sv
// Single-issue binary ALU with a valid/ready handshake on both sides; divide and
// modulo run a serial restoring divider (one bit per cycle), every other op takes one cycle.
module binop_alu #(
  parameter int NBITS = 8,
  localparam int DIV_CYCLES = NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NBITS-1:0] xout,
  output logic [NBITS-1:0] xhi,
  output logic             dz,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [CW-1:0]      cnt;
  logic [NBITS-1:0]   rem;
  logic [NBITS-1:0]   quo;
  logic [NBITS-1:0]   divisor;
  logic               op_mod;

  logic               accept;
  logic               is_div_op;
  logic [NBITS:0]     sum;
  logic [NBITS:0]     diff;
  logic [2*NBITS-1:0] prod;
  logic               shift_ovf;
  logic [NBITS-1:0]   alu_lo;
  logic [NBITS-1:0]   alu_hi;

  logic [NBITS:0]     rsh;
  logic               ge;
  logic [NBITS-1:0]   rem_nx;
  logic [NBITS-1:0]   quo_nx;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign is_div_op = (op == OP_DIV) || (op == OP_MOD);

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign prod      = {{NBITS{1'b0}}, a} * {{NBITS{1'b0}}, b};
  assign shift_ovf = (32'(b) >= 32'(NBITS));

  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    case (op)
      OP_ADD: begin
        alu_lo = sum[NBITS-1:0];
        alu_hi = {{(NBITS-1){1'b0}}, sum[NBITS]};
      end
      OP_SUB: begin
        alu_lo = diff[NBITS-1:0];
        alu_hi = {{(NBITS-1){1'b0}}, diff[NBITS]};
      end
      OP_MUL: begin
        alu_lo = prod[NBITS-1:0];
        alu_hi = prod[2*NBITS-1:NBITS];
      end
      OP_SHL: alu_lo = shift_ovf ? '0 : (a << b);
      OP_SHR: alu_lo = shift_ovf ? '0 : (a >> b);
      OP_XOR: alu_lo = a ^ b;
      default: ;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract when it fits. A zero divisor always "fits", which naturally
  // yields an all-ones quotient and leaves the dividend as the remainder.
  assign rsh    = {rem, quo[NBITS-1]};
  assign ge     = (rsh >= {1'b0, divisor});
  assign rem_nx = ge ? (rsh[NBITS-1:0] - divisor) : rsh[NBITS-1:0];
  assign quo_nx = {quo[NBITS-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      xout    <= '0;
      xhi     <= '0;
      dz      <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      op_mod  <= 1'b0;
    end else if (state == DIV) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(DIV_CYCLES - 1)) begin
        state <= DONE;
        xout  <= op_mod ? rem_nx : quo_nx;
        xhi   <= op_mod ? quo_nx : rem_nx;
        dz    <= (divisor == '0);
      end
    end else if (accept) begin
      if (is_div_op) begin
        state   <= DIV;
        cnt     <= '0;
        rem     <= '0;
        quo     <= a;
        divisor <= b;
        op_mod  <= (op == OP_MOD);
      end else begin
        state <= DONE;
        xout  <= alu_lo;
        xhi   <= alu_hi;
        dz    <= 1'b0;
      end
    end else if ((state == DONE) && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_binop_alu.sv
// Directed bench for binop_alu at NBITS=8: a back-to-back vector table for the
// single-cycle ops plus hand sequences for divide, backpressure and reset.
module tb_binop_alu;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a, b;
  logic [2:0]   op;
  logic         in_valid, in_ready;
  logic [N-1:0] xout, xhi;
  logic         dz, out_valid, out_ready;

  int errors = 0;
  int checks = 0;

  binop_alu #(.NBITS(N)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .xout(xout), .xhi(xhi), .dz(dz),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_lo;
    logic [N-1:0] exp_hi;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide/modulo from IDLE and check the full multi-cycle timeline.
  task automatic do_div(input logic [2:0] o, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [N-1:0] elo, input logic [N-1:0] ehi, input logic edz,
                        input string name);
    int bad;
    bad = 0;
    op = o; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      step();
    end
    chk({name, "_busy_cycles"}, bad, 0);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 1);
    chk({name, "_xout"}, {24'd0, xout}, {24'd0, elo});
    chk({name, "_xhi"}, {24'd0, xhi}, {24'd0, ehi});
    chk({name, "_dz"}, {31'd0, dz}, {31'd0, edz});
    step();
  endtask

  initial begin
    int bad;

    vecs[0]  = '{3'd0, 8'd200, 8'd100, 8'd44,  8'd1};
    vecs[1]  = '{3'd0, 8'd10,  8'd20,  8'd30,  8'd0};
    vecs[2]  = '{3'd0, 8'hFF,  8'h01,  8'h00,  8'd1};
    vecs[3]  = '{3'd1, 8'd3,   8'd5,   8'hFE,  8'd1};
    vecs[4]  = '{3'd1, 8'd9,   8'd4,   8'd5,   8'd0};
    vecs[5]  = '{3'd1, 8'd7,   8'd7,   8'd0,   8'd0};
    vecs[6]  = '{3'd2, 8'hFF,  8'hFF,  8'h01,  8'hFE};
    vecs[7]  = '{3'd2, 8'd12,  8'd13,  8'h9C,  8'h00};
    vecs[8]  = '{3'd2, 8'h80,  8'h02,  8'h00,  8'h01};
    vecs[9]  = '{3'd5, 8'h81,  8'd1,   8'h02,  8'h00};
    vecs[10] = '{3'd5, 8'hFF,  8'd7,   8'h80,  8'h00};
    vecs[11] = '{3'd5, 8'hFF,  8'd8,   8'h00,  8'h00};
    vecs[12] = '{3'd6, 8'h80,  8'd7,   8'h01,  8'h00};
    vecs[13] = '{3'd6, 8'hFF,  8'd200, 8'h00,  8'h00};
    vecs[14] = '{3'd6, 8'hF0,  8'd4,   8'h0F,  8'h00};
    vecs[15] = '{3'd7, 8'hF0,  8'h3C,  8'hCC,  8'h00};

    rst = 1'b1; a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_xout", {24'd0, xout}, 0);
    chk("rst_xhi", {24'd0, xhi}, 0);
    chk("rst_dz", {31'd0, dz}, 0);

    // Back-to-back single-cycle ops: one result per cycle with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 1);
      chk($sformatf("vec%0d_xout", i), {24'd0, xout}, {24'd0, vecs[i].exp_lo});
      chk($sformatf("vec%0d_xhi", i), {24'd0, xhi}, {24'd0, vecs[i].exp_hi});
      chk($sformatf("vec%0d_dz", i), {31'd0, dz}, 0);
    end
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", {31'd0, out_valid}, 0);

    do_div(3'd3, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, "div200_7");
    do_div(3'd4, 8'd200, 8'd7, 8'd4, 8'd28, 1'b0, "mod200_7");
    do_div(3'd3, 8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, "div77_0");

    // The DZ flag must clear on the next ordinary op.
    op = 3'd0; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("add_after_dz_xout", {24'd0, xout}, 2);
    chk("add_after_dz_dz", {31'd0, dz}, 0);
    step();

    do_div(3'd4, 8'd77, 8'd0, 8'd77, 8'hFF, 1'b1, "mod77_0");
    do_div(3'd3, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, "div255_1");
    do_div(3'd3, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, "div5_9");

    // Backpressure: result held, new requests refused while stalled.
    op = 3'd1; a = 8'd3; b = 8'd5; in_valid = 1'b1; out_ready = 1'b0;
    step();
    op = 3'd0; a = 8'd1; b = 8'd1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b1 || xout !== 8'hFE || xhi !== 8'h01 || in_ready !== 1'b0) bad++;
      step();
    end
    chk("stall_hold_cycles", bad, 0);
    chk("stall_xout", {24'd0, xout}, 32'hFE);
    op = 3'd7; a = 8'hF0; b = 8'h3C; out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
    chk("release_out_valid", {31'd0, out_valid}, 1);
    chk("release_xout", {24'd0, xout}, 32'hCC);

    // Reset three cycles into a divide discards it.
    step();
    op = 3'd3; a = 8'd200; b = 8'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("divrst_out_valid", {31'd0, out_valid}, 0);
    chk("divrst_in_ready", {31'd0, in_ready}, 1);
    chk("divrst_xout", {24'd0, xout}, 0);
    chk("divrst_xhi", {24'd0, xhi}, 0);
    chk("divrst_dz", {31'd0, dz}, 0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) bad++;
      step();
    end
    chk("divrst_no_stale", bad, 0);

    // Reset wins over a simultaneous accept.
    op = 3'd0; a = 8'd5; b = 8'd5; in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstacc_out_valid0", {31'd0, out_valid}, 0);
    step();
    chk("rstacc_out_valid1", {31'd0, out_valid}, 0);
    chk("rstacc_xout", {24'd0, xout}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
